// File: rtl/addsub_pipe_fu_if.sv
// addsub_pipe_fu_if: bundle between the add-class reservation station / CDB
// arbiter side (master) and the add/sub/compare functional unit (slave).
//   in_valid/in_ready   issue handshake from the reservation station
//   in_op/in_a/in_b     operation (00 add, 01 sub, 10 slt, 11 sltu) and operands
//   in_tag              destination reservation-station tag
//   flush               discard all in-flight operations
//   cdb_req/cdb_grant   result broadcast handshake with the CDB arbiter
//   cdb_data/tag/ovf    result, its tag, signed overflow (add/sub only)
//   occupancy           number of valid pipeline stages
interface addsub_pipe_fu_if #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             cdb_req;
  logic             cdb_grant;
  logic [WIDTH-1:0] cdb_data;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_ovf;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, cdb_grant,
    input  in_ready, cdb_req, cdb_data, cdb_tag, cdb_ovf, occupancy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, cdb_grant,
    output in_ready, cdb_req, cdb_data, cdb_tag, cdb_ovf, occupancy
  );
endinterface

// File: rtl/addsub_pipe_fu.sv
// addsub_pipe_fu: pipelined integer add/sub/slt/sltu unit for the Tomasulo
// core. Computes the result combinationally from the issue operands, registers
// it into stage 1 with its tag, delays it through stages 2..STAGES and
// presents stage STAGES on the CDB. Stalled stages compress bubbles; a flush
// clears every valid bit on the next edge.
// Ports:
//   clk   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   addsub_pipe_fu_if.slave (issue handshake, flush, CDB handshake,
//         result, occupancy)
module addsub_pipe_fu #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              nRST,
  addsub_pipe_fu_if.slave   bus
);
  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } op_e;

  logic [STAGES:1]  v_q, v_d;
  logic [WIDTH-1:0] data_q [1:STAGES];
  logic [WIDTH-1:0] data_d [1:STAGES];
  logic [TAG_W-1:0] tag_q  [1:STAGES];
  logic [TAG_W-1:0] tag_d  [1:STAGES];
  logic [STAGES:1]  ovf_q, ovf_d;

  logic [STAGES:1]  adv;
  logic             in_ready;
  logic             fire;
  logic [OCC_W-1:0] occ;

  op_e              op;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign op = op_e'(bus.in_op);

  // Subtraction uses the inverted operand with carry-in 1, so one overflow
  // rule (equal input signs, differing result sign) covers both add and sub.
  always_comb begin
    is_sub  = (op == OP_SUB);
    b_eff   = is_sub ? ~bus.in_b : bus.in_b;
    sum     = bus.in_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    res     = '0;
    res_ovf = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        res     = sum;
        res_ovf = (bus.in_a[MSB] == b_eff[MSB]) && (sum[MSB] != bus.in_a[MSB]);
      end
      OP_SLT:  res[0] = ($signed(bus.in_a) < $signed(bus.in_b));
      OP_SLTU: res[0] = (bus.in_a < bus.in_b);
      default: res = '0;
    endcase
  end

  // A stage may accept new contents when the stage ahead advances or it is empty.
  always_comb begin
    adv         = '0;
    adv[STAGES] = bus.cdb_grant || !v_q[STAGES];
    for (int unsigned i = STAGES - 1; i >= 1; i--) begin
      adv[i] = adv[i+1] || !v_q[i];
    end
  end

  assign in_ready = adv[1] && !bus.flush;
  assign fire     = bus.in_valid && in_ready;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    ovf_d  = ovf_q;
    for (int unsigned i = STAGES; i >= 2; i--) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          data_d[i] = data_q[i-1];
          tag_d[i]  = tag_q[i-1];
          ovf_d[i]  = ovf_q[i-1];
        end
      end
    end
    if (adv[1]) begin
      v_d[1] = fire;
      if (fire) begin
        data_d[1] = res;
        tag_d[1]  = bus.in_tag;
        ovf_d[1]  = res_ovf;
      end
    end
    if (bus.flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      v_q   <= '0;
      ovf_q <= '0;
      for (int unsigned i = 1; i <= STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned i = 1; i <= STAGES; i++) begin
      occ = occ + OCC_W'(v_q[i]);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.cdb_req   = v_q[STAGES];
  assign bus.cdb_data  = data_q[STAGES];
  assign bus.cdb_tag   = tag_q[STAGES];
  assign bus.cdb_ovf   = ovf_q[STAGES];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_addsub_pipe_fu.sv
module tb_addsub_pipe_fu;
  localparam int WIDTH  = 32;
  localparam int TAG_W  = 4;
  localparam int STAGES = 3;

  logic clk;
  logic nRST;

  addsub_pipe_fu_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAGES(STAGES)) bus ();

  addsub_pipe_fu #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ordered list of in-flight results, each with the number of
  // edges still needed before it can reach the output.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        o;
    int          w;
  } ent_t;

  ent_t q[$];
  int   nvec = 0;
  int   nchk = 0;
  int   nmis = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    o  = 1'b0;
    case (op)
      2'd0, 2'd1: begin
        full = (op == 2'd0) ? sa + sb : sa - sb;
        r    = full[31:0];
        o    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      2'd2:    r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
  // later, then advance the reference across the rising edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag, input logic g, input logic f);
    logic        exp_rdy, exp_req;
    logic [31:0] r;
    logic        o;
    ent_t        e;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.cdb_grant = g;
    bus.flush     = f;
    #1;
    nvec++;
    exp_rdy = !f && (q.size() < STAGES || g);
    exp_req = (q.size() > 0) && (q[0].w == 0);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
    chk("cdb_req", 32'(bus.cdb_req), 32'(exp_req));
    if (exp_req) begin
      chk("cdb_data", bus.cdb_data, q[0].d);
      chk("cdb_tag", 32'(bus.cdb_tag), 32'(q[0].t));
      chk("cdb_ovf", 32'(bus.cdb_ovf), 32'(q[0].o));
    end
    @(posedge clk);
    if (exp_req && g) void'(q.pop_front());
    foreach (q[i]) if (q[i].w > 0) q[i].w--;
    if (v && exp_rdy) begin
      ref_op(op, a, b, r, o);
      e.d = r; e.t = tag; e.o = o; e.w = STAGES - 1;
      q.push_back(e);
    end
    if (f) q.delete();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, '0, g, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cdb_req", 32'(bus.cdb_req), 32'd0);
    chk("rst_cdb_data", bus.cdb_data, 32'd0);
    chk("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
    chk("rst_cdb_ovf", 32'(bus.cdb_ovf), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.cdb_grant = 1'b0;
    bus.flush     = 1'b0;
    nRST          = 1'b0;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    nRST = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed arithmetic corners, grant held.
    step(1'b1, 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 1'b1, 1'b0);
    step(1'b1, 2'd1, 32'h0000_0005, 32'h0000_0007, 4'd4, 1'b1, 1'b0);
    step(1'b1, 2'd1, 32'h8000_0000, 32'h0000_0001, 4'd5, 1'b1, 1'b0);
    step(1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 1'b1, 1'b0);
    step(1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7, 1'b1, 1'b0);
    idle(STAGES + 2, 1'b1);

    // Eight back-to-back ops, tags 0..7, grant always high.
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'($urandom_range(0, 3)), pick(), pick(), 4'(i), 1'b1, 1'b0);
    idle(STAGES + 2, 1'b1);

    // Backpressure: grant low for 5 cycles while offering 4 ops, then drain.
    for (int i = 0; i < 5; i++)
      step(i < 4, 2'($urandom_range(0, 3)), pick(), pick(), 4'(8 + i), 1'b0, 1'b0);
    idle(STAGES + 3, 1'b1);

    // Fill the pipe, then flush with an op offered in the same cycle.
    for (int i = 0; i < STAGES + 1; i++)
      step(1'b1, 2'd0, pick(), pick(), 4'(i), 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'd11, 32'd22, 4'hF, 1'b1, 1'b1);
    idle(STAGES + 2, 1'b1);

    // Randomized traffic with occasional flushes and stalls.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick(), pick(),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
    idle(STAGES + 3, 1'b1);

    // Asynchronous reset in the middle of a stalled stream.
    for (int i = 0; i < STAGES; i++)
      step(1'b1, 2'd0, 32'd5, 32'd6, 4'(9 + i), 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.cdb_grant = 1'b0;
    #3;
    nRST = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    @(negedge clk);
    nRST = 1'b1;
    step(1'b1, 2'd0, 32'h1234_0000, 32'h0000_5678, 4'd2, 1'b1, 1'b0);
    idle(STAGES + 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
